// File: rtl/ex_mdu_sequencer_if.sv
// Issue/result interface between the EX stage and the multi-cycle
// multiply/divide sequencer.
//
// Handshake: the EX stage raises issue_valid with issue_op/a/b/rd while an
// M-op sits in ID/EX and must keep them stable for as long as ex_stall is
// high. The sequencer answers with exactly one result_valid pulse carrying
// result/result_rd. That pulse is the cycle in which ID/EX advances. flush
// kills the EX-stage instruction in any state, and no result_valid follows it.
interface ex_mdu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            issue_valid;
    logic [2:0]      issue_op;
    logic [XLEN-1:0] issue_a;
    logic [XLEN-1:0] issue_b;
    logic [4:0]      issue_rd;
    logic            flush;
    logic            ex_stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      result_rd;
    logic [1:0]      dbg_state;

    // EX-stage side: issues ops and flushes, observes stall/result
    modport master (
        output issue_valid, issue_op, issue_a, issue_b, issue_rd, flush,
        input  ex_stall, busy, result_valid, result, result_rd, dbg_state
    );

    // Sequencer side
    modport slave (
        input  issue_valid, issue_op, issue_a, issue_b, issue_rd, flush,
        output ex_stall, busy, result_valid, result, result_rd, dbg_state
    );
endinterface

// File: rtl/ex_mdu_sequencer.sv
// Multi-cycle M-extension sequencer beside the EX stage. It runs a shift-add
// multiplier and a restoring divider on magnitudes, fixes the result sign at
// the end, and short-circuits divide-by-zero and signed overflow in one cycle.
module ex_mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    ex_mdu_sequencer_if.slave   mdu
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;       // {hi, lo}: product or {remainder, quotient}
    logic              neg_q, neg_d;       // final result needs negating
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        result_rd_q, result_rd_d;

    // Issue-time decode and operand conditioning
    logic              sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              is_div, div_zero, div_ovf, fast_path;
    logic [XLEN-1:0]   fast_res;
    logic [2*XLEN-1:0] acc_init;
    logic [XLEN-1:0]   opb_init;
    logic              neg_init;

    // Per-iteration datapath and final result formatting
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   final_res;

    // Decode the op held in ID/EX and prepare the magnitudes, sign flag and fast-path result
    always_comb begin
        sgn_a = (mdu.issue_op == OP_MULH) || (mdu.issue_op == OP_MULHSU) ||
                (mdu.issue_op == OP_DIV)  || (mdu.issue_op == OP_REM);
        sgn_b = (mdu.issue_op == OP_MULH) || (mdu.issue_op == OP_DIV) ||
                (mdu.issue_op == OP_REM);
        a_neg = sgn_a & mdu.issue_a[XLEN-1];
        b_neg = sgn_b & mdu.issue_b[XLEN-1];
        abs_a = a_neg ? -mdu.issue_a : mdu.issue_a;
        abs_b = b_neg ? -mdu.issue_b : mdu.issue_b;

        is_div   = mdu.issue_op[2];
        div_zero = is_div && (mdu.issue_b == '0);
        div_ovf  = ((mdu.issue_op == OP_DIV) || (mdu.issue_op == OP_REM)) &&
                   (mdu.issue_a == MIN_INT) && (mdu.issue_b == '1);
        fast_path = div_zero || div_ovf;

        // issue_op[1] separates REM/REMU from DIV/DIVU among the divide ops
        fast_res = '0;
        if (div_zero) begin
            fast_res = mdu.issue_op[1] ? mdu.issue_a : '1;
        end else if (div_ovf) begin
            fast_res = mdu.issue_op[1] ? '0 : mdu.issue_a;
        end

        // Multiply keeps the multiplier in the low half and shifts it out;
        // divide keeps the dividend there and shifts quotient bits in.
        acc_init = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
        opb_init = is_div ? abs_b : abs_a;
        // Remainder follows the dividend; product and quotient follow the sign product
        neg_init = (mdu.issue_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end

    // One multiply or divide iteration, plus sign fix-up of the value it produces
    always_comb begin
        // Shift-add: conditionally add the multiplicand into the high half, then shift right
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder, trial-subtract.
        // The shifted remainder is below twice the divisor, so a set top bit means "fits".
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = div_trial[XLEN] || (div_trial[XLEN-1:0] >= opb_q);
        div_diff  = div_trial[XLEN-1:0] - opb_q;
        div_next  = {(div_ge ? div_diff : div_trial[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

        acc_step = op_q[2] ? div_next : mul_next;

        prod_fix = neg_q ? -acc_step : acc_step;
        quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

        final_res = '0;
        case (op_q)
            OP_MUL:                        final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_res = quo_fix;
            OP_REM, OP_REMU:               final_res = rem_fix;
            default:                       final_res = '0;
        endcase
    end

    // Next-state and register updates for the IDLE/CALC/DONE sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        rd_d        = rd_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        result_d    = result_q;
        result_rd_d = result_rd_q;

        if (mdu.flush) begin
            // Killed instruction: abandon any work, never present a result
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mdu.issue_valid) begin
                        op_d = mdu.issue_op;
                        rd_d = mdu.issue_rd;
                        if (fast_path) begin
                            state_d     = ST_DONE;
                            result_d    = fast_res;
                            result_rd_d = mdu.issue_rd;
                        end else begin
                            state_d = ST_CALC;
                            cnt_d   = CW'(XLEN);
                            acc_d   = acc_init;
                            opb_d   = opb_init;
                            neg_d   = neg_init;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d     = ST_DONE;
                        result_d    = final_res;
                        result_rd_d = rd_q;
                    end
                end
                ST_DONE: begin
                    // ID/EX advances on this edge; a still-high issue_valid is the same op
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            result_rd_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            result_rd_q <= result_rd_d;
        end
    end

    // Pipeline-facing outputs; stall is combinational so the issue cycle itself holds the front end
    always_comb begin
        mdu.ex_stall     = ((state_q == ST_IDLE) && mdu.issue_valid) || (state_q == ST_CALC);
        mdu.busy         = (state_q != ST_IDLE);
        mdu.result_valid = (state_q == ST_DONE) && !mdu.flush;
        mdu.result       = result_q;
        mdu.result_rd    = result_rd_q;
        mdu.dbg_state    = state_q;
    end
endmodule

// File: doc/ex_mdu_sequencer.md
Name: ex_mdu_sequencer

Overview:
Multi-cycle multiply/divide sequencer attached beside the EX stage of the 5-stage core. It accepts an M-extension op held in ID/EX and stalls the front of the pipeline while it iterates. It then presents a one-cycle result that the EX stage muxes into the EX/MEM ALU-output slot in place of the single-cycle ALU result. It owns its shift-add multiplier and restoring divider, a cycle counter and the stall/flush sequencing.

Parameters:
XLEN, 32, operand/result width; counter width is clog2(XLEN)+1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
issue_valid  input  1  ID/EX holds an M-op; held stable while ex_stall is high
issue_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
issue_a  input  XLEN  rs1 value, already forwarded
issue_b  input  XLEN  rs2 value, already forwarded
issue_rd  input  5  destination register
flush  input  1  branch/exception kill of the EX-stage instruction
ex_stall  output  1  hold PC, IF/ID and ID/EX
busy  output  1  state != IDLE
result_valid  output  1  one-cycle pulse; result is to be written into EX/MEM
result  output  XLEN  M-op result
result_rd  output  5  rd captured at issue

Behaviour:
- Reset value of each output: ex_stall 0, busy 0, result_valid 0, result 0, result_rd 0.
- Priority: reset, then flush, then normal operation.
- States:
  - IDLE: waiting for an op.
  - CALC: iterating, with counter cnt.
  - DONE: result presented.
- IDLE to CALC: on a clk edge with issue_valid=1 and no fast path.
  - Capture op, rd, |a| and |b| (signed ops only), result-sign flags, and cnt=XLEN.
- IDLE to DONE (fast path, 1 stall cycle):
  - Divisor 0: DIV/DIVU result all-ones; REM/REMU result a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- CALC: one iteration per cycle, cnt decrements; at cnt==1 go to DONE.
  - Multiply: 2*XLEN accumulator; add the multiplicand when the multiplier LSB is 1, then shift.
  - Divide: restoring divide, shift remainder left, trial-subtract, set quotient bit.
- DONE: result_valid=1 and result driven; go to IDLE unconditionally.
  - issue_valid seen in DONE is the same instruction and is not reissued; ID/EX advances on this edge.
- ex_stall is combinational: (IDLE & issue_valid) | CALC. It is 0 in DONE.
- Latency, iterative op: issue in cycle 0, ex_stall high for cycles 0..XLEN (33 cycles), result_valid in cycle XLEN+1.
- Latency, fast-path op: ex_stall high for cycle 0 only, result_valid in cycle 1.
- Result selection:
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits after sign correction. Correction is two's-complement negation of the full 2*XLEN product when exactly one operand is negative.
    - MULHSU treats only a as signed.
  - DIV quotient is negated if the operand signs differ.
  - REM remainder takes the sign of a.
- result and result_rd hold their value after DONE until the next DONE.
- Flush in any state: go to IDLE on the next edge; no result_valid. Flush together with issue_valid in IDLE does not start an op. ex_stall still follows the combinational rule during the flush cycle.
- Reset mid-CALC: IDLE next cycle; all outputs return to reset values.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> ex_stall high 33 cycles; result_valid in cycle 33; result=0xFFFFFFEB; result_rd = issued rd.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE. Same operands with MULH -> result=0x00000000.
- DIV a=-20, b=6 -> result=0xFFFFFFFD (-3). REM with the same operands -> result=0xFFFFFFFE (-2).
- DIVU a=5, b=0 -> ex_stall 1 cycle; result_valid next cycle; result=0xFFFFFFFF. REMU a=5, b=0 -> result=5.
- DIV a=0x80000000, b=0xFFFFFFFF -> fast path; result=0x80000000. REM with the same operands -> result=0.
- Issue DIVU 100/7, assert flush at CALC cycle 10 -> busy low next cycle; no result_valid. An immediately following MUL 3*4 completes with result=12.
